// File: rtl/game_soc_pkg.sv
// ============================================================================
// game_soc_pkg : register map offsets and bit positions for the keycode port
// Rev 1.0
// ============================================================================
`default_nettype none

package game_soc_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IRQMSK = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int DATA_VALID_BIT  = 8;

  localparam int ST_EMPTY_BIT    = 8;
  localparam int ST_FULL_BIT     = 9;
  localparam int ST_OVF_BIT      = 10;

  localparam int IRQ_NE_BIT      = 0;
  localparam int IRQ_OVF_BIT     = 1;

  localparam int CTRL_FLUSH_BIT  = 0;

endpackage

`default_nettype wire

// File: rtl/game_soc_sync_fifo.sv
// ============================================================================
// game_soc_sync_fifo : first-word-fall-through FIFO with flush and occupancy
// Rev 1.0
// ============================================================================
`default_nettype none

module game_soc_sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Flush overrides both sides; full/empty are sampled at the start of the cycle.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only observed after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/game_soc_keycode_rx.sv
// ============================================================================
// game_soc_keycode_rx : Avalon-MM keycode input port with FIFO and interrupt
// Rev 1.0
// ============================================================================
`default_nettype none

module game_soc_keycode_rx
  import game_soc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [DATA_W-1:0] in_keycode,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  logic              rd_en;
  logic              wr_en;
  logic              pop_req;
  logic              flush_req;
  logic              ovf_set;
  logic              ovf_clr;

  logic              overflow_q, overflow_d;
  logic [1:0]        irqmask_q, irqmask_d;
  logic              unused_writedata;

  assign rd_en     = chipselect & ~read_n;
  assign wr_en     = chipselect & ~write_n;
  assign pop_req   = rd_en & (address == REG_DATA);
  assign flush_req = wr_en & (address == REG_CTRL) & writedata[CTRL_FLUSH_BIT];
  assign ovf_clr   = wr_en & (address == REG_STATUS) & writedata[ST_OVF_BIT];
  // A keycode arriving during a flush is discarded, not counted as a drop.
  assign ovf_set   = in_valid & fifo_full & ~flush_req;

  assign unused_writedata = ^{writedata[31:11], writedata[9:2]};

  game_soc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (in_valid),
    .wdata_i (in_keycode),
    .pop_i   (pop_req),
    .flush_i (flush_req),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (ovf_set) overflow_d = 1'b1;
    irqmask_d = irqmask_q;
    if (wr_en && (address == REG_IRQMSK)) irqmask_d = writedata[1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      irqmask_q  <= 2'b00;
    end else begin
      overflow_q <= overflow_d;
      irqmask_q  <= irqmask_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA: begin
        if (!fifo_empty) begin
          readdata[DATA_W-1:0]     = fifo_head;
          readdata[DATA_VALID_BIT] = 1'b1;
        end
      end
      REG_STATUS: begin
        readdata[CNT_W-1:0]    = fifo_count;
        readdata[ST_EMPTY_BIT] = fifo_empty;
        readdata[ST_FULL_BIT]  = fifo_full;
        readdata[ST_OVF_BIT]   = overflow_q;
      end
      REG_IRQMSK: readdata[1:0] = irqmask_q;
      default:    readdata = '0;
    endcase
  end

  assign irq      = (irqmask_q[IRQ_NE_BIT] & ~fifo_empty) | (irqmask_q[IRQ_OVF_BIT] & overflow_q);
  assign in_ready = ~fifo_full;

endmodule

`default_nettype wire
